ctx_stack_sequencer: RTL and testbench
======================================

Name: ctx_stack_sequencer

Overview:
- Parametrised call/interrupt context sequencer that replaces the fixed 16-bit PC/flags push-pop state machine in the memory stage.
- Splits a PC_W-bit PC, plus optional FLAG_W-bit flags, into WORD_W-bit beats and pushes or pops them on a descending stack through a single-port data memory.
- Owns the stack pointer.
- Adds operation types, depth checks and a ready/done handshake, none of which the earlier machine had.

Parameters:
- PC_W, 32, program counter width.
- FLAG_W, 3, flag register width; must satisfy FLAG_W <= WORD_W.
- WORD_W, 16, data memory word width.
- SP_W, 11, stack pointer / memory address width.
- SP_INIT, 2**SP_W-1, stack pointer value after reset (empty-stack top).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_op  in  2  operation: 00 CALL, 01 INT, 10 RET, 11 RTI.
- req_pc  in  PC_W  PC to push (CALL/INT).
- req_flags  in  FLAG_W  flags to push (INT).
- req_ready  out  1  high only in IDLE.
- mem_addr  out  SP_W  memory address.
- mem_wdata  out  WORD_W  memory write data.
- mem_we  out  1  write strobe, one word per cycle.
- mem_re  out  1  read strobe.
- mem_rdata  in  WORD_W  read data, valid the cycle after mem_re.
- done_valid  out  1  one-cycle completion pulse.
- done_pc  out  PC_W  popped PC (RET/RTI) or echoed req_pc (CALL/INT).
- done_flags  out  FLAG_W  popped flags (RTI); otherwise 0.
- err_valid  out  1  one-cycle overflow/underflow pulse.
- busy  out  1  not IDLE.
- sp  out  SP_W  current stack pointer.

Behaviour:
- Beat count: NP = ceil(PC_W/WORD_W). K = NP for CALL/RET; K = NP+1 for INT/RTI.
- Reset (reset==0 at an edge):
  - State returns to IDLE; sp = SP_INIT.
  - All outputs 0 except req_ready = 1.
  - Any in-flight sequence is abandoned; no further mem_we/mem_re is issued.
- Handshake:
  - A request is accepted when req_valid && req_ready at the edge ending cycle t.
  - req_op, req_pc and req_flags are latched at acceptance.
  - req_valid while busy is ignored; nothing is queued.
- Depth check at acceptance:
  - Push: free = sp+1. If free < K, the request is rejected.
  - Pop: used = SP_INIT-sp. If used < K, the request is rejected.
  - On rejection: err_valid=1 in cycle t+1, then IDLE. No memory access, sp unchanged, no done_valid.
- FSM: IDLE -> PUSH | POP | ERR; PUSH -> DONE; POP -> POP_WAIT -> DONE; ERR -> IDLE; DONE -> IDLE.
- PUSH (cycles t+1..t+K), one beat per cycle, post-decrement:
  - mem_we=1, mem_addr=sp, then sp-=1.
  - Beat order: PC most-significant word first down to least-significant; then, for INT, flags zero-extended to WORD_W.
  - PC zero-extended to NP*WORD_W.
- POP (cycles t+1..t+K), pre-increment:
  - mem_re=1, mem_addr=sp+1, sp+=1.
  - Beat order is the reverse of push: flags (RTI only), then PC least-significant word up to most-significant.
  - mem_rdata is captured one cycle after each read (POP_WAIT covers the final capture).
  - Flags are taken from rdata[FLAG_W-1:0].
- DONE:
  - done_valid=1 for exactly one cycle.
  - Push completion at t+K+1; pop completion at t+K+2.
  - done_pc and done_flags hold their values until the next done_valid.
- mem_wdata = 0 whenever mem_we = 0. mem_we and mem_re are never both high.
- sp arithmetic is SP_W bits; the depth check guarantees it never wraps.

Test Plan (defaults; sp starts 0x7FF):
1. CALL req_pc=0x0001_2345 -> t+1: we, addr 0x7FF, data 0x0001; t+2: addr 0x7FE, data 0x2345; t+3: done_valid, done_pc=0x00012345; sp=0x7FD.
2. Then RET -> reads at 0x7FE and 0x7FF; done_valid at t+4, done_pc=0x00012345, done_flags=0; sp=0x7FF.
3. INT pc=0xABCD_0010, flags=3'b101 -> writes 0xABCD@7FF, 0x0010@7FE, 0x0005@7FD; sp=0x7FC. Then RTI -> done_pc=0xABCD0010, done_flags=3'b101, sp=0x7FF.
4. RET on empty stack -> err_valid at t+1; no mem_re; sp stays 0x7FF; req_ready back to 1 at t+2.
5. SP_W=2, SP_INIT=3: CALL succeeds (sp=1); then INT (K=3, free=2) -> err_valid, no writes, sp=1.
6. reset=0 in the first PUSH cycle -> next cycle busy=0, mem_we=0, sp=SP_INIT, no done_valid. A req_valid pulse during busy in any scenario produces no extra memory access.

Source files
------------

// File: rtl/ctx_stack_sequencer.sv
// ctx_stack_sequencer: pushes/pops PC and optional flags as word beats on a descending memory stack
module ctx_stack_sequencer #(
  parameter int PC_W = 32,
  parameter int FLAG_W = 3,
  parameter int WORD_W = 16,
  parameter int SP_W = 11,
  parameter logic [SP_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [PC_W-1:0]   req_pc,
  input  logic [FLAG_W-1:0] req_flags,
  output logic              req_ready,
  output logic [SP_W-1:0]   mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              done_valid,
  output logic [PC_W-1:0]   done_pc,
  output logic [FLAG_W-1:0] done_flags,
  output logic              err_valid,
  output logic              busy,
  output logic [SP_W-1:0]   sp
);
  localparam int NP = (PC_W + WORD_W - 1) / WORD_W;
  localparam int PW = NP * WORD_W;
  localparam int TW = PW + WORD_W;
  typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, ERR, DONE} state_t;
  state_t state;
  logic with_flags;
  logic pend;
  logic rej;
  logic [PC_W-1:0] pc;
  logic [TW-1:0] sh, nsh;
  logic [SP_W:0] cnt, k, free, used;
  always_comb begin
    k = (SP_W+1)'(NP) + (SP_W+1)'(req_op[0]);
    free = {1'b0, sp} + (SP_W+1)'(1);
    used = {1'b0, SP_INIT} - {1'b0, sp};
    rej = req_op[1] ? used < k : free < k;
    nsh = {mem_rdata, sh[TW-1:WORD_W]};
    req_ready = state == IDLE;
    busy = state != IDLE;
    mem_we = state == PUSH;
    mem_re = state == POP;
    mem_addr = mem_we ? sp : mem_re ? sp + SP_W'(1) : '0;
    mem_wdata = mem_we ? sh[TW-1 -: WORD_W] : '0;
    done_valid = state == DONE;
    err_valid = state == ERR;
  end
  // Pop beats shift in from the top, so after the last capture the PC sits in the upper words
  // and RTI flags land in the bottom word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sp <= SP_INIT;
      done_pc <= '0;
      done_flags <= '0;
      pend <= 1'b0;
      with_flags <= 1'b0;
      pc <= '0;
      sh <= '0;
      cnt <= '0;
    end else begin
      pend <= state == POP;
      case (state)
        IDLE: if (req_valid) begin
          with_flags <= req_op[0];
          pc <= req_pc;
          cnt <= k - (SP_W+1)'(1);
          sh <= {PW'(req_pc), WORD_W'(req_flags)};
          state <= rej ? ERR : req_op[1] ? POP : PUSH;
        end
        PUSH: begin
          sp <= sp - SP_W'(1);
          sh <= sh << WORD_W;
          cnt <= cnt - (SP_W+1)'(1);
          if (cnt == '0) begin
            state <= DONE;
            done_pc <= pc;
            done_flags <= '0;
          end
        end
        POP: begin
          sp <= sp + SP_W'(1);
          cnt <= cnt - (SP_W+1)'(1);
          if (pend) sh <= nsh;
          if (cnt == '0) state <= POP_WAIT;
        end
        POP_WAIT: begin
          done_pc <= nsh[WORD_W +: PC_W];
          done_flags <= with_flags ? nsh[FLAG_W-1:0] : '0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ctx_stack_sequencer.sv
// tb_ctx_stack_sequencer: directed vector table plus cycle-level sequences on two configurations
module tb_ctx_stack_sequencer;
  logic clk = 0;
  logic reset = 0;
  logic sel = 0;
  logic rq_v = 0;
  logic [1:0] rq_op = 0;
  logic [31:0] rq_pc = 0;
  logic [2:0] rq_fl = 0;
  int checks = 0;
  int errors = 0;

  logic d1_ready, d1_we, d1_re, d1_done, d1_err, d1_busy;
  logic [10:0] d1_addr, d1_sp;
  logic [15:0] d1_wdata, d1_rdata;
  logic [31:0] d1_pc;
  logic [2:0] d1_fl;
  logic d2_ready, d2_we, d2_re, d2_done, d2_err, d2_busy;
  logic [1:0] d2_addr, d2_sp;
  logic [15:0] d2_wdata, d2_rdata;
  logic [31:0] d2_pc;
  logic [2:0] d2_fl;
  logic [15:0] mem1 [0:2047];
  logic [15:0] mem2 [0:3];

  always #5 clk = ~clk;

  ctx_stack_sequencer dut1 (
    .clk(clk), .reset(reset), .req_valid(rq_v && !sel), .req_op(rq_op), .req_pc(rq_pc),
    .req_flags(rq_fl), .req_ready(d1_ready), .mem_addr(d1_addr), .mem_wdata(d1_wdata),
    .mem_we(d1_we), .mem_re(d1_re), .mem_rdata(d1_rdata), .done_valid(d1_done),
    .done_pc(d1_pc), .done_flags(d1_fl), .err_valid(d1_err), .busy(d1_busy), .sp(d1_sp)
  );

  ctx_stack_sequencer #(.SP_W(2), .SP_INIT(2'd3)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rq_v && sel), .req_op(rq_op), .req_pc(rq_pc),
    .req_flags(rq_fl), .req_ready(d2_ready), .mem_addr(d2_addr), .mem_wdata(d2_wdata),
    .mem_we(d2_we), .mem_re(d2_re), .mem_rdata(d2_rdata), .done_valid(d2_done),
    .done_pc(d2_pc), .done_flags(d2_fl), .err_valid(d2_err), .busy(d2_busy), .sp(d2_sp)
  );

  always @(posedge clk) begin
    if (d1_we) mem1[d1_addr] <= d1_wdata;
    if (d1_re) d1_rdata <= mem1[d1_addr];
    if (d2_we) mem2[d2_addr] <= d2_wdata;
    if (d2_re) d2_rdata <= mem2[d2_addr];
  end

  wire o_we = sel ? d2_we : d1_we;
  wire o_re = sel ? d2_re : d1_re;
  wire o_done = sel ? d2_done : d1_done;
  wire o_err = sel ? d2_err : d1_err;
  wire o_ready = sel ? d2_ready : d1_ready;
  wire [31:0] o_pc = sel ? d2_pc : d1_pc;
  wire [2:0] o_fl = sel ? d2_fl : d1_fl;
  wire [10:0] o_sp = sel ? {9'd0, d2_sp} : d1_sp;

  typedef struct {
    logic [1:0] op;
    logic [31:0] pc;
    logic [2:0] fl;
    logic err;
    logic [31:0] epc;
    logic [2:0] efl;
    logic [10:0] esp;
    int lat;
    int acc;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] pc, input logic [2:0] fl);
    @(negedge clk);
    rq_v = 1; rq_op = op; rq_pc = pc; rq_fl = fl;
    @(posedge clk);
    #1 rq_v = 0;
  endtask

  // One request end to end; a stray req_valid is raised during the busy window.
  task automatic run(input vec_t v, input string tag);
    int n = 0;
    int a = 0;
    bit fin = 0;
    issue(v.op, v.pc, v.fl);
    while (!fin && n < 20) begin
      @(negedge clk);
      n++;
      if (o_we || o_re) a++;
      if (o_we && o_re) chk({tag, "_we_re_both"}, 1, 0);
      rq_v = (n == 1) && !v.err;
      if (o_done || o_err) fin = 1;
    end
    rq_v = 0;
    chk({tag, "_finished"}, 64'(fin), 1);
    chk({tag, "_err"}, 64'(o_err), 64'(v.err));
    chk({tag, "_latency"}, 64'(n), 64'(v.lat));
    chk({tag, "_accesses"}, 64'(a), 64'(v.acc));
    if (!v.err) begin
      chk({tag, "_done_pc"}, 64'(o_pc), 64'(v.epc));
      chk({tag, "_done_flags"}, 64'(o_fl), 64'(v.efl));
    end
    chk({tag, "_sp"}, 64'(o_sp), 64'(v.esp));
    @(negedge clk);
    chk({tag, "_ready_after"}, {o_ready, o_done, o_err, o_we, o_re}, 5'b10000);
  endtask

  initial begin
    tbl[0] = '{2'b00, 32'h0001_2345, 3'd0, 0, 32'h0001_2345, 3'd0, 11'h7FD, 3, 2};
    tbl[1] = '{2'b10, 32'h0, 3'd0, 0, 32'h0001_2345, 3'd0, 11'h7FF, 4, 2};
    tbl[2] = '{2'b01, 32'hABCD_0010, 3'b101, 0, 32'hABCD_0010, 3'd0, 11'h7FC, 4, 3};
    tbl[3] = '{2'b11, 32'h0, 3'd0, 0, 32'hABCD_0010, 3'b101, 11'h7FF, 5, 3};
    tbl[4] = '{2'b10, 32'h0, 3'd0, 1, 32'h0, 3'd0, 11'h7FF, 1, 0};
    tbl[5] = '{2'b11, 32'h0, 3'd0, 1, 32'h0, 3'd0, 11'h7FF, 1, 0};
    tbl[6] = '{2'b00, 32'hDEAD_BEEF, 3'd7, 0, 32'hDEAD_BEEF, 3'd0, 11'h7FD, 3, 2};
    tbl[7] = '{2'b01, 32'h1234_5678, 3'b010, 0, 32'h1234_5678, 3'd0, 11'h7FA, 4, 3};
    tbl[8] = '{2'b11, 32'h0, 3'd0, 0, 32'h1234_5678, 3'b010, 11'h7FD, 5, 3};
    tbl[9] = '{2'b10, 32'h0, 3'd0, 0, 32'hDEAD_BEEF, 3'd0, 11'h7FF, 4, 2};

    repeat (2) @(negedge clk);
    chk("reset_state", {d1_ready, d1_busy, d1_we, d1_re, d1_done, d1_err}, 6'b100000);
    chk("reset_sp", 64'(d1_sp), 64'h7FF);
    chk("reset_bus", {d1_addr, d1_wdata, d1_pc, d1_fl}, 0);
    reset = 1;

    issue(2'b00, 32'h0001_2345, 3'd0);
    @(negedge clk);
    chk("call_b0", {d1_we, d1_re, d1_busy, d1_ready, d1_addr, d1_wdata}, {4'b1010, 11'h7FF, 16'h0001});
    @(negedge clk);
    chk("call_b1", {d1_we, d1_re, d1_addr, d1_wdata}, {2'b10, 11'h7FE, 16'h2345});
    @(negedge clk);
    chk("call_done", {d1_done, d1_we, d1_wdata, d1_sp, d1_pc}, {2'b10, 16'h0, 11'h7FD, 32'h0001_2345});
    issue(2'b10, 32'h0, 3'd0);
    @(negedge clk);
    chk("ret_r0", {d1_re, d1_we, d1_addr}, {2'b10, 11'h7FE});
    @(negedge clk);
    chk("ret_r1", {d1_re, d1_we, d1_addr}, {2'b10, 11'h7FF});
    @(negedge clk);
    chk("ret_wait", {d1_re, d1_we, d1_done, d1_busy}, 4'b0001);
    @(negedge clk);
    chk("ret_done", {d1_done, d1_sp, d1_pc, d1_fl}, {1'b1, 11'h7FF, 32'h0001_2345, 3'd0});

    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));
    chk("mem_7ff", 64'(mem1[11'h7FF]), 64'hDEAD);
    chk("mem_7fe", 64'(mem1[11'h7FE]), 64'hBEEF);
    chk("mem_7fd", 64'(mem1[11'h7FD]), 64'h1234);
    chk("mem_7fc", 64'(mem1[11'h7FC]), 64'h5678);
    chk("mem_7fb", 64'(mem1[11'h7FB]), 64'h0002);

    issue(2'b00, 32'h5555_AAAA, 3'd0);
    @(negedge clk);
    chk("rst_mid_push_we", 64'(d1_we), 1);
    reset = 0;
    @(negedge clk);
    chk("rst_mid_push", {d1_busy, d1_we, d1_re, d1_done, d1_ready, d1_sp}, {5'b00001, 11'h7FF});
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_quiet", {d1_done, d1_we, d1_re, d1_busy}, 4'b0000);
    end

    sel = 1;
    run('{2'b00, 32'h1111_2222, 3'd0, 0, 32'h1111_2222, 3'd0, 11'd1, 3, 2}, "small_call");
    run('{2'b01, 32'h3333_4444, 3'd1, 1, 32'h0, 3'd0, 11'd1, 1, 0}, "small_int_ovf");
    run('{2'b11, 32'h0, 3'd0, 1, 32'h0, 3'd0, 11'd1, 1, 0}, "small_rti_unf");
    run('{2'b10, 32'h0, 3'd0, 0, 32'h1111_2222, 3'd0, 11'd3, 4, 2}, "small_ret");
    sel = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
